// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MAC_BUSY = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam int unsigned MAC_CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detection: the ID instruction reads a register that the load in EX
// has not yet produced.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  output logic       load_use
);

  always_comb begin
    load_use = ex_memread & ex_regwrite & (ex_rd != REG_ZERO) &
               ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use stalls, taken-branch flushes,
// multi-cycle MAC occupancy of EX, and a stall-cycle performance counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MAC_CYCLES = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic             ex_mac,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             mac_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t               state, state_nxt;
  logic [MAC_CNT_W-1:0] mac_cnt, mac_cnt_nxt;
  logic                 load_use;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .ex_regwrite (ex_regwrite),
    .load_use    (load_use)
  );

  // Mealy outputs; rst is included so the reset values appear asynchronously.
  always_comb begin
    state_nxt    = state;
    mac_cnt_nxt  = mac_cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    mac_busy     = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state == MAC_BUSY) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      mac_busy    = 1'b1;
      if (mac_cnt == '0) begin
        id_ex_bubble = 1'b1;
        state_nxt    = IDLE;
      end else begin
        id_ex_hold  = 1'b1;
        mac_cnt_nxt = mac_cnt - MAC_CNT_W'(1);
      end
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_mac && (MAC_CYCLES > 1)) begin
      // First MAC cycle is this one; the final one releases with a bubble.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_hold  = 1'b1;
      mac_busy    = 1'b1;
      state_nxt   = MAC_BUSY;
      mac_cnt_nxt = MAC_CNT_W'(MAC_CYCLES - 2);
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mac_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mac_cnt <= mac_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_write) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a queue-based scoreboard.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // Expected control bundle: {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, mac_busy}
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] LU   = 6'b000100;
  localparam logic [5:0] BR   = 6'b111100;
  localparam logic [5:0] MACH = 6'b000011;
  localparam logic [5:0] MACB = 6'b000101;
  localparam logic [5:0] RSTV = 6'b000100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1 = '0;
  logic [4:0]       id_rs2 = '0;
  logic             id_uses_rs2 = 1'b0;
  logic [4:0]       ex_rd = '0;
  logic             ex_memread = 1'b0;
  logic             ex_regwrite = 1'b0;
  logic             ex_mac = 1'b0;
  logic             ex_branch_taken = 1'b0;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, mac_busy;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct {
    int         idx;
    logic [5:0] ctl;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   vec    = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAC_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_regwrite     (ex_regwrite),
    .ex_mac          (ex_mac),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .id_ex_hold      (id_ex_hold),
    .mac_busy        (mac_busy),
    .stall_cycles    (stall_cycles)
  );

  // One cycle of stimulus, applied 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic mr,
                     input logic rw, input logic mac, input logic br,
                     input logic [5:0] ectl, input logic [3:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_rd = rd;
    ex_memread = mr; ex_regwrite = rw; ex_mac = mac; ex_branch_taken = br;
    e.idx = vec; e.ctl = ectl; e.cnt = ecnt;
    exp_q.push_back(e);
    vec++;
  endtask

  // Monitor: compare on the falling edge whenever an expectation is pending.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, mac_busy};
        checks++;
        if (act !== e.ctl) begin
          fails++;
          $display("FAIL ctl vec %0d: got %b expected %b", e.idx, act, e.ctl);
        end
        checks++;
        if (stall_cycles !== e.cnt) begin
          fails++;
          $display("FAIL stall_cycles vec %0d: got %0d expected %0d", e.idx, stall_cycles, e.cnt);
        end
        checks++;
        if (id_ex_hold && id_ex_bubble) begin
          fails++;
          $display("FAIL hold_bubble_excl vec %0d: got hold=1 bubble=1 expected not both", e.idx);
        end
      end
    end
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: got no completion expected completion by 100000");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    //  rst rs1    rs2    u2  rd     mr  rw  mac br   ctl   cnt
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, RSTV, 4'd0);
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, RSTV, 4'd0);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 4'd0);
    // load-use on rs1, then bubble clears memread
    cyc(0, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0, LU,   4'd0);
    cyc(0, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 4'd1);
    // x0 destination never stalls
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 0, NORM, 4'd1);
    // rs2 gating
    cyc(0, 5'd3, 5'd7, 0, 5'd7, 1, 1, 0, 0, NORM, 4'd1);
    cyc(0, 5'd3, 5'd7, 1, 5'd7, 1, 1, 0, 0, LU,   4'd1);
    cyc(0, 5'd3, 5'd7, 1, 5'd0, 0, 0, 0, 0, NORM, 4'd2);
    // MAC: hold, hold, bubble, then released
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MACH, 4'd2);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MACH, 4'd3);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MACB, 4'd4);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 4'd5);
    // branch wins over simultaneous load-use
    cyc(0, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 1, BR,   4'd5);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 4'd5);
    // branch and load-use ignored while MAC is busy
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MACH, 4'd5);
    cyc(0, 5'd5, 5'd0, 0, 5'd5, 1, 1, 1, 1, MACH, 4'd6);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MACB, 4'd7);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 4'd8);
    // reset asserted asynchronously in the second MAC cycle
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, MACH, 4'd8);
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, RSTV, 4'd0);
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, RSTV, 4'd0);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 4'd0);
    // 17 held load-use cycles wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      cyc(0, 5'd9, 5'd0, 0, 5'd9, 1, 1, 0, 0, LU, 4'(i));
    end
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, NORM, 4'd1);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
